pwm_speed_sequencer: RTL
========================

# pwm_speed_sequencer

Sequencing controller for the 3-bit-speed PWM generator. It accepts speed/enable commands over a valid/ready handshake and drives the generator's `enable` and `speed` inputs. Speed changes ramp one step at a time at a programmable interval, so the load never sees a step change. It sits between the top-level pin/command logic and the PWM datapath.

## Interface
Parameters:
- `RAMP_DIV`, default 1024: clock cycles per one-step speed change; legal range 1..65535.
- `CNT_W`, default 16: prescaler width; must satisfy 2^CNT_W ≥ RAMP_DIV.

Ports:
- `clk`  in  1  single clock; all state is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  block enable; low forces an abort (see Operation).
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command can be accepted this cycle.
- `cmd_speed`  in  3  target speed, 0..7.
- `cmd_enable`  in  1  1 = run at `cmd_speed`; 0 = stop.
- `pwm_enable`  out  1  drives the generator's enable input.
- `pwm_speed`  out  3  drives the generator's speed input.
- `busy`  out  1  high while a ramp or stop is in progress.
- `done`  out  1  one-cycle pulse when the commanded state is reached.

## Operation
State machine states:
- IDLE
- RAMP_UP
- RAMP_DOWN
- STOPPING (present only with the macro)

Handshake:
- `cmd_ready` = `ena` && state==IDLE.
- A command is accepted on a clock edge where `cmd_valid` && `cmd_ready`.
- On accept, the block latches `target`=`cmd_speed` and clears the prescaler.

Run command (`cmd_enable`=1):
- If `pwm_enable` was 0: `pwm_enable`←1 and `pwm_speed`←0 on the accept edge.
- Next state:
  - RAMP_UP if target > current speed.
  - RAMP_DOWN if target < current speed.
  - Otherwise stay in IDLE and pulse `done` in the following cycle.

Ramping:
- The prescaler increments every cycle while in RAMP_UP, RAMP_DOWN or STOPPING.
- When prescaler==RAMP_DIV-1:
  - The prescaler clears.
  - `pwm_speed` moves ±1 toward target (down for STOPPING).
- When the step reaches target: state→IDLE and `done`=1 for exactly one cycle.
- `pwm_speed` never wraps. It saturates at 0 and 7 by construction, because target is 0..7.

Stop command (`cmd_enable`=0):
- Without the macro:
  - `pwm_enable`←0 and `pwm_speed`←0 on the accept edge.
  - State stays IDLE; `done` pulses next cycle.
- With the macro: see Configuration.
- A stop command while already stopped: no output change; `done` still pulses.

Abort and reset:
- `ena` low, at any state, is synchronous: state→IDLE, `pwm_enable`←0, `pwm_speed`←0, prescaler←0, no `done` pulse.
- `rst_n` low, asynchronous: same values as abort, plus `done`=0.
- Reset values: `pwm_enable`=0, `pwm_speed`=0, `busy`=0, `done`=0.
- `cmd_ready`=0 while `ena`=0.
- Commands cannot arrive mid-ramp (`cmd_ready`=0). A held `cmd_valid` is accepted on the first IDLE cycle.

Derived outputs:
- `busy` = state != IDLE (registered state; no combinational path from inputs).

## Timing
- Accept edge T; nth speed step at edge T + n·RAMP_DIV.
- Full 0→7 ramp: 7·RAMP_DIV cycles. `done` is high in the cycle after edge T + 7·RAMP_DIV.
- `cmd_ready` rises in the cycle after the final step (the same cycle `done` is high).
- Equal-target or immediate-stop commands: `done` in cycle T+1. Back-to-back accept is possible at T+1.
- The `ena` abort takes effect on the first edge with `ena`=0.
- All outputs are registered except `cmd_ready` (state && `ena`).

## Configuration
- Macro: `PWM_SEQ_SOFTSTOP_EN`.
- Defined, stop command when `pwm_speed`>0:
  - Enter STOPPING and ramp down at RAMP_DIV per step, with `pwm_enable` held 1.
  - On the edge where speed reaches 0: `pwm_enable`←0, state→IDLE, `done` pulses.
- Defined, stop command when `pwm_speed`==0: same as the undefined case.
- Undefined: the STOPPING state and its logic are not compiled; stop is immediate.

## Test plan
- Reset, then enable: hold `rst_n`=0 and release with `ena`=1 → `pwm_enable`=0, `pwm_speed`=0, `cmd_ready`=1, `busy`=0.
- Ramp up (RAMP_DIV=4): accept run/speed 5 from stopped → `pwm_enable`=1 at T. Speed is 1,2,3,4,5 at edges T+4..T+20. `done` is a single pulse after T+20. `cmd_ready`=0 throughout the ramp.
- Ramp down (RAMP_DIV=4): from speed 5, run/speed 2 → speed is 4,3,2 at T+4, T+8, T+12. `done` follows. `pwm_enable` stays 1.
- Same target and held `cmd_valid`: run/speed 5 at speed 5 → no state change, `done` at T+1. A second command held valid during a ramp is accepted only after `done`.
- Abort: drop `ena` mid-ramp at speed 3 → next edge `pwm_enable`=0, `pwm_speed`=0, no `done`. Asserting `rst_n`=0 mid-cycle clears the outputs immediately.
- Stop command from speed 7 (RAMP_DIV=4):
  - With `PWM_SEQ_SOFTSTOP_EN`: speed steps 6..0 over 28 cycles, then `pwm_enable`=0 and `done`.
  - Without: `pwm_enable`=0 and `pwm_speed`=0 at T, `done` at T+1.

Source files
------------

// File: rtl/pwm_speed_sequencer.sv
// pwm_speed_sequencer: command sequencer for the 3-bit-speed PWM generator.
// Accepts run/stop commands over a valid/ready handshake and ramps the
// generator speed one step every RAMP_DIV cycles toward the commanded target.
// Optional soft stop (ramp down to 0 before disabling) is compiled in when the
// macro PWM_SEQ_SOFTSTOP_EN is defined; otherwise a stop is immediate.
module pwm_speed_sequencer #(
  parameter int RAMP_DIV = 1024,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_speed,
  input  logic       cmd_enable,
  output logic       pwm_enable,
  output logic [2:0] pwm_speed,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] TICK_VAL = CNT_W'(RAMP_DIV - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
`ifdef PWM_SEQ_SOFTSTOP_EN
    ,STOPPING = 2'd3
`endif
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] prescaler, prescaler_n;
  logic [2:0]       target, target_n;
  logic [2:0]       speed_n;
  logic             enable_n;
  logic             done_n;
  logic             accept;
  logic             tick;

  assign cmd_ready = ena && (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = (prescaler == TICK_VAL);

  // State and output registers; reset clears everything including done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      prescaler  <= '0;
      target     <= '0;
      pwm_enable <= 1'b0;
      pwm_speed  <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      prescaler  <= prescaler_n;
      target     <= target_n;
      pwm_enable <= enable_n;
      pwm_speed  <= speed_n;
      done       <= done_n;
    end
  end

  // Next-state logic: ena low aborts to IDLE from anywhere.
  always_comb begin
    state_n = state;
    if (!ena) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (cmd_enable) begin
              // A stopped generator always sits at speed 0, so pwm_speed
              // is the current speed in both cases.
              if (cmd_speed > pwm_speed)      state_n = RAMP_UP;
              else if (cmd_speed < pwm_speed) state_n = RAMP_DOWN;
              else                            state_n = IDLE;
            end else begin
`ifdef PWM_SEQ_SOFTSTOP_EN
              if (pwm_speed != 3'd0) state_n = STOPPING;
              else                   state_n = IDLE;
`else
              state_n = IDLE;
`endif
            end
          end
        end
        RAMP_UP: begin
          if (tick && ((pwm_speed + 3'd1) == target)) state_n = IDLE;
        end
        RAMP_DOWN: begin
          if (tick && ((pwm_speed - 3'd1) == target)) state_n = IDLE;
        end
`ifdef PWM_SEQ_SOFTSTOP_EN
        STOPPING: begin
          if (tick && (pwm_speed == 3'd1)) state_n = IDLE;
        end
`endif
        default: state_n = IDLE;
      endcase
    end
  end

  // Output/datapath next values: prescaler, target, enable, speed, done pulse.
  always_comb begin
    prescaler_n = prescaler;
    target_n    = target;
    enable_n    = pwm_enable;
    speed_n     = pwm_speed;
    done_n      = 1'b0;
    if (!ena) begin
      prescaler_n = '0;
      enable_n    = 1'b0;
      speed_n     = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            target_n    = cmd_speed;
            prescaler_n = '0;
            if (cmd_enable) begin
              if (!pwm_enable) begin
                enable_n = 1'b1;
                speed_n  = '0;
              end
              if (cmd_speed == pwm_speed) done_n = 1'b1;
            end else begin
`ifdef PWM_SEQ_SOFTSTOP_EN
              // Running: keep enable high and let STOPPING ramp to zero.
              if (pwm_speed == 3'd0) begin
                enable_n = 1'b0;
                speed_n  = '0;
                done_n   = 1'b1;
              end
`else
              enable_n = 1'b0;
              speed_n  = '0;
              done_n   = 1'b1;
`endif
            end
          end
        end
        RAMP_UP: begin
          prescaler_n = prescaler + CNT_W'(1);
          if (tick) begin
            prescaler_n = '0;
            speed_n     = pwm_speed + 3'd1;
            if ((pwm_speed + 3'd1) == target) done_n = 1'b1;
          end
        end
        RAMP_DOWN: begin
          prescaler_n = prescaler + CNT_W'(1);
          if (tick) begin
            prescaler_n = '0;
            speed_n     = pwm_speed - 3'd1;
            if ((pwm_speed - 3'd1) == target) done_n = 1'b1;
          end
        end
`ifdef PWM_SEQ_SOFTSTOP_EN
        STOPPING: begin
          prescaler_n = prescaler + CNT_W'(1);
          if (tick) begin
            prescaler_n = '0;
            speed_n     = pwm_speed - 3'd1;
            if (pwm_speed == 3'd1) begin
              enable_n = 1'b0;
              done_n   = 1'b1;
            end
          end
        end
`endif
        default: begin
          prescaler_n = '0;
        end
      endcase
    end
  end

endmodule
